// File: rtl/env_vca_pkg.sv
// env_vca_pkg: shared envelope-interface constants and VCA state encodings.
package env_vca_pkg;
  typedef enum logic [1:0] {
    VCA_IDLE = 2'd0,
    VCA_MUL  = 2'd1
  } vca_state_t;
  localparam int ENV_W = 8;
  localparam logic [ENV_W-1:0] ENV_UNITY = 8'hFF;
  localparam logic [ENV_W-1:0] ENV_MUTE = 8'h00;
  localparam int MUL_STEPS = 8;
endpackage

// File: rtl/env_vca.sv
// env_vca: applies an 8-bit envelope as gain to a signed sample using a bit-serial shift-add multiplier.
module env_vca
  import env_vca_pkg::*;
#(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ENV_W-1:0]    envelope,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                out_valid
);
  localparam int AW = SAMPLE_W + ENV_W + 1;
  localparam logic [2:0] LAST = 3'(MUL_STEPS - 1);
  vca_state_t state, state_n;
  logic [SAMPLE_W:0] mag, mag_in, sext, res_mag;
  logic [SAMPLE_W-1:0] res;
  logic [ENV_W-1:0] env;
  logic neg, done;
  logic [AW-1:0] acc, acc_n;
  logic [2:0] cnt;
  assign in_ready = state == VCA_IDLE;
  assign sext = {sample_in[SAMPLE_W-1], sample_in};
  assign mag_in = sample_in[SAMPLE_W-1] ? -sext : sext;
  always_comb begin
    done = state == VCA_MUL && cnt == LAST;
    state_n = state == VCA_IDLE ? (in_valid ? VCA_MUL : VCA_IDLE) : (done ? VCA_IDLE : VCA_MUL);
    acc_n = acc + (env[cnt] ? AW'(mag) << cnt : '0);
    // unity bypasses the >>8 so full scale (incl. most negative) passes exactly
    res_mag = env == ENV_UNITY ? mag : acc_n[AW-1:ENV_W];
    res = neg ? SAMPLE_W'(-res_mag) : res_mag[SAMPLE_W-1:0];
  end
  always_ff @(posedge clk)
    if (!rstn) state <= VCA_IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sample_out <= '0;
      out_valid <= 1'b0;
      acc <= '0;
      cnt <= '0;
      mag <= '0;
      neg <= 1'b0;
      env <= ENV_MUTE;
    end else begin
      out_valid <= done;
      if (in_ready && in_valid) begin
        mag <= mag_in;
        neg <= sample_in[SAMPLE_W-1];
        env <= envelope;
        acc <= '0;
        cnt <= '0;
      end else if (state == VCA_MUL) begin
        acc <= acc_n;
        cnt <= cnt + 1'b1;
      end
      if (done) sample_out <= res;
    end
  end
endmodule
